// File: rtl/fp4_stream_unpack.sv
// FP4 (E2M1) to FP9 (1/5/3, bias 15) streaming gearbox: one wide packed word in,
// BEATS narrow beats out, with per-word IEEE-like/OCP format and sticky exception flags.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_EMPTY | no word held; out_valid=0, in_ready=1
// S_FULL  | word held; beat cnt_q is presented on the output
module fp4_stream_unpack #(
  parameter int IN_LANES  = 8,
  parameter int OUT_LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*IN_LANES-1:0]  in_data,
  input  logic                   in_fmt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [9*OUT_LANES-1:0] out_data,
  output logic [OUT_LANES-1:0]   out_invalid,
  output logic                   out_last,
  input  logic                   flag_clr,
  output logic                   sticky_invalid,
  output logic                   sticky_inf
);

  localparam int BEATS = IN_LANES / OUT_LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [4*IN_LANES-1:0]  word_q, word_d;
  logic                   fmt_q, fmt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sticky_invalid_q, sticky_invalid_d;
  logic                   sticky_inf_q, sticky_inf_d;

  logic                   full;
  logic                   in_hs;
  logic                   out_hs;
  logic                   last_beat;
  logic [31:0]            beat_shift;
  logic [4*IN_LANES-1:0]  word_sh;
  logic [4*OUT_LANES-1:0] beat_nib;
  logic [9*OUT_LANES-1:0] lane_fp9;
  logic [OUT_LANES-1:0]   lane_nan;
  logic [OUT_LANES-1:0]   lane_inf;

  function automatic logic [8:0] fp4_to_fp9(input logic [3:0] nib, input logic ocp);
    logic [8:0] res;
    logic       s;
    logic       m;
    s = nib[3];
    m = nib[0];
    case (nib[2:1])
      2'b00:   res = m ? {s, 5'b01110, 3'b000} : {s, 8'b0};
      2'b01:   res = {s, 5'b01111, m, 2'b00};
      2'b10:   res = {s, 5'b10000, m, 2'b00};
      default: res = ocp ? {s, 5'b10001, m, 2'b00} : {s, 5'b11111, 2'b00, m};
    endcase
    return res;
  endfunction

  assign full      = (state_q == S_FULL);
  assign last_beat = full && (cnt_q == CNT_LAST);
  assign out_hs    = full & out_ready;
  // Refilling on the last handshake keeps back-to-back words bubble-free.
  assign in_ready  = ~full | (out_ready & last_beat);
  assign in_hs     = in_valid & in_ready;

  always_comb begin
    beat_shift = 32'(cnt_q) * 32'(4 * OUT_LANES);
    word_sh    = word_q >> beat_shift;
    beat_nib   = word_sh[4*OUT_LANES-1:0];
  end

  always_comb begin
    lane_fp9 = '0;
    lane_nan = '0;
    lane_inf = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      lane_fp9[9*j +: 9] = fp4_to_fp9(beat_nib[4*j +: 4], fmt_q);
      lane_nan[j] = ~fmt_q & (beat_nib[4*j+2 -: 2] == 2'b11) &  beat_nib[4*j];
      lane_inf[j] = ~fmt_q & (beat_nib[4*j+2 -: 2] == 2'b11) & ~beat_nib[4*j];
    end
  end

  assign out_valid      = full;
  assign out_data       = lane_fp9;
  assign out_invalid    = full ? lane_nan : '0;
  assign out_last       = last_beat;
  assign sticky_invalid = sticky_invalid_q;
  assign sticky_inf     = sticky_inf_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    fmt_d   = fmt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_EMPTY: begin
        if (in_hs) begin
          state_d = S_FULL;
          word_d  = in_data;
          fmt_d   = in_fmt;
          cnt_d   = '0;
        end
      end
      S_FULL: begin
        if (out_hs) begin
          if (last_beat) begin
            cnt_d = '0;
            if (in_hs) begin
              word_d = in_data;
              fmt_d  = in_fmt;
            end else begin
              state_d = S_EMPTY;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // A set from the current handshake overrides a simultaneous clear.
  always_comb begin
    sticky_invalid_d = sticky_invalid_q;
    sticky_inf_d     = sticky_inf_q;
    if (flag_clr) begin
      sticky_invalid_d = 1'b0;
      sticky_inf_d     = 1'b0;
    end
    if (out_hs) begin
      sticky_invalid_d = sticky_invalid_d | (|lane_nan);
      sticky_inf_d     = sticky_inf_d | (|lane_inf);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_EMPTY;
      word_q           <= '0;
      fmt_q            <= 1'b0;
      cnt_q            <= '0;
      sticky_invalid_q <= 1'b0;
      sticky_inf_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_q           <= word_d;
      fmt_q            <= fmt_d;
      cnt_q            <= cnt_d;
      sticky_invalid_q <= sticky_invalid_d;
      sticky_inf_q     <= sticky_inf_d;
    end
  end

endmodule
